// File: rtl/fetch_queue_if.sv
// Fetch/decode-side signal bundle for fetch_queue.
// master: the queue itself; slave: the fetch stage plus decode around it.
interface fetch_queue_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 2
);
  logic [XLEN-1:0]   fetch_instr_in;
  logic [XLEN-1:0]   fetch_pc_in;
  logic [1:0]        pc_op_out;
  logic [XLEN-1:0]   pc_load_out;
  logic              redirect_in;
  logic [XLEN-1:0]   redirect_pc_in;
  logic              dec_valid_out;
  logic              dec_ready_in;
  logic [XLEN-1:0]   dec_instr_out;
  logic [XLEN-1:0]   dec_pc_out;
  logic [ADDR_W:0]   count_out;

  modport master (
    input  fetch_instr_in, fetch_pc_in, redirect_in, redirect_pc_in, dec_ready_in,
    output pc_op_out, pc_load_out, dec_valid_out, dec_instr_out, dec_pc_out, count_out
  );

  modport slave (
    output fetch_instr_in, fetch_pc_in, redirect_in, redirect_pc_in, dec_ready_in,
    input  pc_op_out, pc_load_out, dec_valid_out, dec_instr_out, dec_pc_out, count_out
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. Captures {PC, instruction} pairs into a
// small FIFO, holds fetch when full, and flushes/redirects fetch on a taken branch/jump.
module fetch_queue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.master  bus
);
  localparam int unsigned PtrW = ADDR_W + 1;

  localparam logic [1:0] OpInc  = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpHold = 2'b10;

  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [PtrW-1:0]   rd_ptr, wr_ptr, count;
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic              full, valid, push, pop;
  logic [1:0]        pc_op;

  assign rd_idx = rd_ptr[ADDR_W-1:0];
  assign wr_idx = wr_ptr[ADDR_W-1:0];
  assign full   = (count == PtrW'(DEPTH));
  assign valid  = (count != '0);

  // Fetch PC control: redirect wins, then hold when full, else keep incrementing.
  always_comb begin
    pc_op           = OpInc;
    bus.pc_load_out = '0;
    if (bus.redirect_in) begin
      pc_op           = OpLoad;
      bus.pc_load_out = bus.redirect_pc_in;
    end else if (full) begin
      pc_op = OpHold;
    end
  end

  assign bus.pc_op_out = pc_op;

  // An increment means fetch is leaving its current PC, so that pair is captured now.
  assign push = (pc_op == OpInc);
  assign pop  = valid & bus.dec_ready_in & ~bus.redirect_in;

  // Head entry presented to decode; reads zero when empty.
  always_comb begin
    bus.dec_valid_out = valid;
    bus.dec_instr_out = '0;
    bus.dec_pc_out    = '0;
    if (valid) begin
      bus.dec_instr_out = instr_mem[rd_idx];
      bus.dec_pc_out    = pc_mem[rd_idx];
    end
  end

  assign bus.count_out = count;

  // Pointer and occupancy state; a redirect flushes and suppresses both push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage; push never targets a live entry because fetch is held when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_idx]    <= bus.fetch_pc_in;
      instr_mem[wr_idx] <= bus.fetch_instr_in;
    end
  end
endmodule
